// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl: turn-signal/hazard lamp controller with comfort blink.
// Define TURN_SIGNAL_DIAG_EN to enable bulb-fault fast blink in LEFT/RIGHT.
module turn_signal_ctrl #(
  parameter int BLINK_HALF  = 16,
  parameter int NUM_FLASHES = 5,
  parameter int FLASH_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               E,
  input  logic               L,
  input  logic               R,
  input  logic               fault_l,
  input  logic               fault_r,
  output logic [1:0]         state,
  output logic               lamp_l,
  output logic               lamp_r,
  output logic [FLASH_W-1:0] flash_cnt
);
  localparam int CW = $clog2(BLINK_HALF + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] FAST_M1 = CW'(BLINK_HALF / 2 - 1);
  localparam logic [FLASH_W-1:0] MIN_FL = FLASH_W'(NUM_FLASHES);

  typedef enum logic [1:0] {IDLE = 2'b00, RIGHT = 2'b01, LEFT = 2'b10, HAZ = 2'b11} st_e;

  st_e                state_q, state_d;
  logic               l_q, r_q, phase_q, phase_d, fast_q, fast_d;
  logic               lamp_l_q, lamp_l_d, lamp_r_q, lamp_r_d;
  logic [CW-1:0]      cnt_q, cnt_d, lim;
  logic [FLASH_W-1:0] flash_q, flash_d;
  logic               rise_l, rise_r, one_l, one_r, restart, wrap, fault_next;

  assign rise_l = L & ~l_q;
  assign rise_r = R & ~r_q;
  assign one_l  = rise_l & ~rise_r;
  assign one_r  = rise_r & ~rise_l;
  assign lim    = fast_q ? FAST_M1 : FULL_M1;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    restart = 1'b0;
    wrap    = 1'b0;
    if (E && state_q != HAZ) begin
      state_d = HAZ;
      restart = 1'b1;
    end else if (!E && state_q == HAZ) begin
      state_d = IDLE;
      phase_d = 1'b0;
      cnt_d   = '0;
    end else if (!E && one_l && state_q != LEFT) begin
      state_d = LEFT;
      restart = 1'b1;
    end else if (!E && one_r && state_q != RIGHT) begin
      state_d = RIGHT;
      restart = 1'b1;
    end else if (state_q != IDLE) begin
      if (cnt_q == lim) begin
        wrap    = 1'b1;
        cnt_d   = '0;
        phase_d = ~phase_q;
        if (phase_q)
          flash_d = &flash_q ? flash_q : flash_q + 1'b1;
        // turns end only at an off->on boundary so the last flash is never clipped
        else if (state_q != HAZ && !(state_q == LEFT ? L : R) && flash_q >= MIN_FL) begin
          state_d = IDLE;
          phase_d = 1'b0;
        end
      end else
        cnt_d = cnt_q + 1'b1;
    end
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
      flash_d = '0;
    end
  end

`ifdef TURN_SIGNAL_DIAG_EN
  assign fault_next = (state_d == LEFT && fault_l) || (state_d == RIGHT && fault_r);
`else
  logic unused_fault;
  assign unused_fault = fault_l ^ fault_r;
  assign fault_next   = 1'b0;
`endif

  // half-period length is latched only at entry or wrap so a running half is never cut short
  assign fast_d   = (restart || wrap) ? fault_next : fast_q;
  assign lamp_l_d = phase_d && (state_d == LEFT || state_d == HAZ);
  assign lamp_r_d = phase_d && (state_d == RIGHT || state_d == HAZ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      l_q      <= 1'b0;
      r_q      <= 1'b0;
      phase_q  <= 1'b0;
      fast_q   <= 1'b0;
      cnt_q    <= '0;
      flash_q  <= '0;
      lamp_l_q <= 1'b0;
      lamp_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      l_q      <= L;
      r_q      <= R;
      phase_q  <= phase_d;
      fast_q   <= fast_d;
      cnt_q    <= cnt_d;
      flash_q  <= flash_d;
      lamp_l_q <= lamp_l_d;
      lamp_r_q <= lamp_r_d;
    end
  end

  assign state     = state_q;
  assign lamp_l    = lamp_l_q;
  assign lamp_r    = lamp_r_q;
  assign flash_cnt = flash_q;
endmodule
